// File: rtl/sin_interp_osc.sv
// sin_interp_osc: time-multiplexed multi-channel sine oscillator.
//
// One phase accumulator per channel. On each tick the block sweeps every channel
// through a 4-stage pipeline:
//   S0 issue  : read the phase, then advance the accumulator by the channel's frequency word.
//   S1 fold   : fold the phase onto the quarter-wave table and drive rom_adrs.
//   S2 lookup : capture the base sample and interpolate with diff * frac.
//   S3 output : saturate, apply the sign and present out_data/out_ch/out_valid.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   tick                   sample strobe; starts a sweep when idle
//   freq_we/ch/data        frequency-word write port
//   rom_adrs               registered address to the external base/diff ROMs
//   rom_base, rom_diff     combinational ROM read data
//   busy                   sweep in progress
//   overrun                sticky; tick seen while busy
//   out_valid/ch/data      signed output sample stream
//
// Optional feature (macro OSC_HARDSYNC_EN): adds sync_we/sync_ch. These zero one
// channel's accumulator. A sync wins over a simultaneous S0 increment.
module sin_interp_osc #(
    parameter int unsigned NCH     = 8,
    parameter int unsigned PHASE_W = 24,
    parameter int unsigned ADRS_W  = 9,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CH_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              freq_we,
    input  logic [CH_W-1:0]   freq_ch,
    input  logic [PHASE_W-1:0] freq_data,
`ifdef OSC_HARDSYNC_EN
    input  logic              sync_we,
    input  logic [CH_W-1:0]   sync_ch,
`endif
    output logic [ADRS_W-1:0] rom_adrs,
    input  logic [DATA_W-1:0] rom_base,
    input  logic [DATA_W-1:0] rom_diff,
    output logic              busy,
    output logic              overrun,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W:0]   out_data
);

    localparam int unsigned FIELD_W = PHASE_W - 2;
    localparam int unsigned FRAC_W  = PHASE_W - 2 - ADRS_W;
    localparam int unsigned PROD_W  = DATA_W + FRAC_W;

    typedef enum logic {StIdle, StSweep} state_t;

    state_t            state, state_next;
    logic [CH_W-1:0]   ch_cnt, ch_cnt_next;
    logic              issue;

    logic [PHASE_W-1:0] acc  [NCH];
    logic [PHASE_W-1:0] freq [NCH];

    // Pipeline registers
    logic               v_s1, v_s2, v_s3;
    logic [CH_W-1:0]    ch_s1, ch_s2, ch_s3;
    logic [PHASE_W-1:0] phase_s1;
    logic [FRAC_W-1:0]  frac_s2;
    logic               neg_s2, neg_s3;
    logic [DATA_W-1:0]  base_s3, prod_s3;

    logic [1:0]         quad;
    logic [FIELD_W-1:0] field;
    logic [PROD_W-1:0]  prod_full;
    logic               unused_prod_lo;
    logic [DATA_W:0]    sum;
    logic [DATA_W-1:0]  mag;
    logic [DATA_W:0]    mag_ext;

    // Sweep FSM
    always_comb begin
        state_next  = state;
        ch_cnt_next = ch_cnt;
        issue       = 1'b0;
        case (state)
            StIdle: begin
                if (tick) begin
                    state_next  = StSweep;
                    ch_cnt_next = '0;
                end
            end
            StSweep: begin
                issue = 1'b1;
                if (ch_cnt == CH_W'(NCH - 1)) begin
                    state_next = StIdle;
                end else begin
                    ch_cnt_next = ch_cnt + 1'b1;
                end
            end
            default: state_next = StIdle;
        endcase
    end

    assign busy = (state == StSweep);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            ch_cnt  <= '0;
            overrun <= 1'b0;
        end else begin
            state  <= state_next;
            ch_cnt <= ch_cnt_next;
            // A tick on the final issue edge is also dropped, since the state is still sweeping
            if (tick && state == StSweep) begin
                overrun <= 1'b1;
            end
        end
    end

    // Frequency words and accumulators. The issue reads pre-edge values, so a write or
    // sync on the same edge does not affect the sample being issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i]  <= '0;
                freq[i] <= '0;
            end
        end else begin
            if (freq_we && (int'(freq_ch) < NCH)) begin
                freq[freq_ch] <= freq_data;
            end
            for (int i = 0; i < NCH; i++) begin
                if (issue && ch_cnt == CH_W'(i)) begin
                    acc[i] <= acc[i] + freq[i];
                end
`ifdef OSC_HARDSYNC_EN
                if (sync_we && sync_ch == CH_W'(i)) begin
                    acc[i] <= '0;
                end
`endif
            end
        end
    end

    // Quarter-wave fold: odd quadrants run the table backwards, upper half is negated
    assign quad  = phase_s1[PHASE_W-1 -: 2];
    assign field = quad[0] ? ~phase_s1[FIELD_W-1:0] : phase_s1[FIELD_W-1:0];

    assign prod_full      = PROD_W'(rom_diff) * PROD_W'(frac_s2);
    assign unused_prod_lo = ^prod_full[FRAC_W-1:0];

    assign sum     = {1'b0, base_s3} + {1'b0, prod_s3};
    assign mag     = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
    assign mag_ext = {1'b0, mag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_s1      <= 1'b0;
            v_s2      <= 1'b0;
            v_s3      <= 1'b0;
            ch_s1     <= '0;
            ch_s2     <= '0;
            ch_s3     <= '0;
            phase_s1  <= '0;
            rom_adrs  <= '0;
            frac_s2   <= '0;
            neg_s2    <= 1'b0;
            neg_s3    <= 1'b0;
            base_s3   <= '0;
            prod_s3   <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else begin
            // S0
            v_s1     <= issue;
            ch_s1    <= ch_cnt;
            phase_s1 <= acc[ch_cnt];
            // S1
            v_s2     <= v_s1;
            ch_s2    <= ch_s1;
            rom_adrs <= field[FIELD_W-1 -: ADRS_W];
            frac_s2  <= field[FRAC_W-1:0];
            neg_s2   <= quad[1];
            // S2
            v_s3     <= v_s2;
            ch_s3    <= ch_s2;
            neg_s3   <= neg_s2;
            base_s3  <= rom_base;
            prod_s3  <= prod_full[PROD_W-1:FRAC_W];
            // S3
            out_valid <= v_s3;
            if (v_s3) begin
                out_ch   <= ch_s3;
                out_data <= neg_s3 ? ((DATA_W+1)'(0) - mag_ext) : mag_ext;
            end
        end
    end

endmodule

// File: tb/tb_sin_interp_osc.sv
module tb_sin_interp_osc;

    localparam int unsigned NCH     = 8;
    localparam int unsigned PHASE_W = 24;
    localparam int unsigned ADRS_W  = 9;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CH_W    = 3;

    logic                clk;
    logic                rst_n;
    logic                tick;
    logic                freq_we;
    logic [CH_W-1:0]     freq_ch;
    logic [PHASE_W-1:0]  freq_data;
`ifdef OSC_HARDSYNC_EN
    logic                sync_we;
    logic [CH_W-1:0]     sync_ch;
`endif
    logic [ADRS_W-1:0]   rom_adrs;
    logic [DATA_W-1:0]   rom_base;
    logic [DATA_W-1:0]   rom_diff;
    logic                busy;
    logic                overrun;
    logic                out_valid;
    logic [CH_W-1:0]     out_ch;
    logic [DATA_W:0]     out_data;

    sin_interp_osc #(
        .NCH     (NCH),
        .PHASE_W (PHASE_W),
        .ADRS_W  (ADRS_W),
        .DATA_W  (DATA_W),
        .CH_W    (CH_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .freq_we   (freq_we),
        .freq_ch   (freq_ch),
        .freq_data (freq_data),
`ifdef OSC_HARDSYNC_EN
        .sync_we   (sync_we),
        .sync_ch   (sync_ch),
`endif
        .rom_adrs  (rom_adrs),
        .rom_base  (rom_base),
        .rom_diff  (rom_diff),
        .busy      (busy),
        .overrun   (overrun),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data)
    );

    // Bench ROMs: base[a] = a << 6, diff = 64 everywhere
    assign rom_base = DATA_W'({rom_adrs, 6'b0});
    assign rom_diff = 16'd64;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [CH_W+DATA_W:0] exp_q[$];

    // Monitor: every out_valid cycle pops one expected {ch, data}
    always @(negedge clk) begin
        if (out_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: got ch=%0d data=%h, required no output",
                         out_ch, out_data);
            end else begin
                logic [CH_W+DATA_W:0] e;
                e = exp_q.pop_front();
                if ({out_ch, out_data} !== e) begin
                    n_bad++;
                    $display("FAIL sample: got ch=%0d data=%h, required ch=%0d data=%h",
                             out_ch, out_data, e[CH_W+DATA_W -: CH_W], e[DATA_W:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: got busy=1 after 100 cycles, required busy=0");
        end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Starts one sweep (back-to-back if the block just went idle) and queues its samples.
    // Channels 3..7 never get a frequency word, so they always produce 0.
    task automatic sweep(input logic [DATA_W:0] d0, input logic [DATA_W:0] d1,
                         input logic [DATA_W:0] d2);
        wait_idle();
        tick = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            logic [DATA_W:0] d;
            d = (c == 0) ? d0 : (c == 1) ? d1 : (c == 2) ? d2 : '0;
            exp_q.push_back({CH_W'(c), d});
        end
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic write_freq(input logic [CH_W-1:0] ch, input logic [PHASE_W-1:0] data);
        freq_we   = 1'b1;
        freq_ch   = ch;
        freq_data = data;
        @(negedge clk);
        freq_we   = 1'b0;
    endtask

    initial begin
        int nb;
        rst_n     = 1'b0;
        tick      = 1'b0;
        freq_we   = 1'b0;
        freq_ch   = '0;
        freq_data = '0;
`ifdef OSC_HARDSYNC_EN
        sync_we   = 1'b0;
        sync_ch   = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_rom_adrs", 32'(rom_adrs), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Sweep A: all freq=0. The freq[0] write lands on ch0's issue edge, so ch0 keeps
        // phase 0 for this sweep and its accumulator does not move.
        sweep('0, '0, '0);
        freq_we   = 1'b1;
        freq_ch   = 3'd0;
        freq_data = 24'h200000;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) nb++;
            @(negedge clk);
            freq_we = 1'b0;
        end
        check("busy_cycles", nb, 8);

        // Sweeps B, C: ch0 phase 0 then 0x200000 -> adrs 256, frac 0 -> +16384
        sweep('0, '0, '0);
        sweep(17'd16384, '0, '0);

        // freq[1]=0x400000; sweeps D..G run back-to-back
        wait_idle();
        write_freq(3'd1, 24'h400000);
        sweep(17'd32767, '0, '0);                    // ch0 0x400000
        sweep(17'd16383, 17'd32767, '0);             // ch0 0x600000, ch1 0x400000
        sweep('0, '0, '0);                           // both at 0x800000
        sweep(-17'sd16384, -17'sd32767, '0);         // ch0 0xA00000, ch1 0xC00000

        // Sweep H with a stray tick in the middle: ignored, overrun sticks
        check("overrun_before", 32'(overrun), 0);
        sweep(-17'sd32767, '0, '0);                  // ch0 0xC00000, ch1 wrapped to 0
        repeat (2) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("overrun_set", 32'(overrun), 1);
        wait_idle();
        drain();
        repeat (5) @(negedge clk);
        check("overrun_sticky", 32'(overrun), 1);
        check("busy_after_overrun", 32'(busy), 0);

        // Abort: reset while ch0 sits in the lookup stage
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_out_data", 32'(out_data), 0);
        check("abort_out_ch", 32'(out_ch), 0);
        check("abort_rom_adrs", 32'(rom_adrs), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_overrun", 32'(overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_restart", 32'(busy), 0);

        // Sweep I: everything cleared, all channels at phase 0
        sweep('0, '0, '0);
        drain();

`ifdef OSC_HARDSYNC_EN
        wait_idle();
        write_freq(3'd2, 24'h100000);
        sweep('0, '0, '0);
        sweep('0, '0, 17'd8192);                     // ch2 0x100000 -> adrs 128
        sweep('0, '0, 17'd16384);                    // ch2 0x200000 -> adrs 256
        wait_idle();
        sync_we = 1'b1;
        sync_ch = 3'd2;
        @(negedge clk);
        sync_we = 1'b0;
        sweep('0, '0, '0);                           // zeroed; would be 24576 unsynced
        drain();
`endif

        repeat (10) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sin_interp_osc.md
Name: sin_interp_osc

Overview:
- Time-multiplexed, multi-channel sine oscillator for the synth voice path.
- Keeps one phase accumulator per channel and folds each phase onto a quarter-wave table.
- Reads an external base-sine ROM and an external difference ROM (one entry per address), then linearly interpolates between entries using the phase fraction.
- One channel is processed per clock in a 4-stage pipeline. This produces signed samples for the mixer.

Parameters:
- NCH, 8: number of oscillator channels (1..64).
- PHASE_W, 24: phase accumulator and frequency word width.
- ADRS_W, 9: quarter-wave table address width (512 entries).
- DATA_W, 16: unsigned width of the base and difference ROM words.
- CH_W, 3: channel index width, at least clog2(NCH).

Ports:
- clk in 1: system clock, rising-edge.
- rst_n in 1: asynchronous active-low reset.
- tick in 1: sample-rate strobe; starts one sweep over all channels.
- freq_we in 1: frequency-word write enable.
- freq_ch in CH_W: channel to write.
- freq_data in PHASE_W: phase increment per tick.
- rom_adrs out ADRS_W: registered address to both external ROMs.
- rom_base in DATA_W: base sine value at rom_adrs (combinational ROM).
- rom_diff in DATA_W: base[a+1]-base[a] at rom_adrs (combinational ROM).
- busy out 1: sweep in progress.
- overrun out 1: sticky; tick arrived while busy.
- out_valid out 1: out_data/out_ch valid this cycle.
- out_ch out CH_W: channel of out_data.
- out_data out DATA_W+1: signed two's-complement sample.

Behaviour:
- Reset (async, rst_n=0): all accumulators, frequency registers and pipeline registers clear; busy=0, overrun=0, out_valid=0, out_ch=0, out_data=0, rom_adrs=0. Reset mid-sweep aborts the sweep, and no further out_valid pulses occur.
- FRAC_W = PHASE_W-2-ADRS_W (13 at defaults); must be at least 1.
- Sweep FSM has two states:
  - IDLE: tick=1 moves to SWEEP with ch_cnt=0 and busy=1.
  - SWEEP: issues channel ch_cnt each cycle, ch_cnt++. After issuing NCH-1 it returns to IDLE with busy=0.
  - A tick seen in SWEEP is ignored and sets overrun (cleared only by reset).
  - A tick on the same edge that SWEEP ends is also ignored and sets overrun.
- S0 (issue): phase_s1 <= acc[ch]; acc[ch] <= acc[ch]+freq[ch] mod 2^PHASE_W. The output therefore reflects the phase before the increment.
- S1 (fold):
  - q = phase[PHASE_W-1:PHASE_W-2]; field = the low PHASE_W-2 bits.
  - If q[0]=1, field = ~field (bitwise).
  - rom_adrs <= field[top ADRS_W]; frac_s2 <= field[FRAC_W-1:0]; neg_s2 <= q[1].
- S2 (lookup): base_s3 <= rom_base; prod_s3 <= (rom_diff*frac_s2) >> FRAC_W, truncating.
- S3 (output):
  - mag = base_s3+prod_s3, saturated to 2^DATA_W-1.
  - out_data <= neg ? -mag : mag; out_valid <= 1; out_ch <= channel.
  - out_valid is low whenever no channel occupies S3.
- Latency: a tick captured at edge E0 produces channel c at S3 after edge E(4+c). The valid burst is NCH consecutive cycles.
- Frequency write takes effect at the clock edge. If a write lands on the same edge as the issue of that channel, the issue uses the old value. Writes are allowed at any time; freq_ch values of NCH or above are ignored.
- Back-to-back sweeps: the next tick may arrive the cycle after busy falls; the pipeline drains without bubbles or corruption.

Optional Feature:
- OSC_HARDSYNC_EN. When defined, the block adds two inputs, sync_we (1 bit) and sync_ch (CH_W bits).
  - sync_we=1 zeroes acc[sync_ch] at that edge.
  - If sync_we coincides with the issue of that channel, the issue reads the old phase and the accumulator ends at 0, not old+freq.
- When undefined, these ports do not exist and the accumulators are modified only by S0.

Test Plan:
- Bench ROMs use base[a]=a<<6 and diff=64 throughout.
- Reset with NCH=8 and all freq=0, then tick: 8 out_valid cycles, out_ch 0..7, out_data=0 for each, busy high for 8 cycles.
- Set freq[0]=0x200000, then tick twice: the 2nd sweep's ch0 has phase 0x200000, giving rom_adrs=256, frac=0, out_data=+16384.
- Set freq[1]=0x400000 and give four ticks: ch1 outputs in order are 0, +32767, 0, -32767.
  - 0x400000 folds to adrs 511, frac 8191, so 32704+63.
  - 0x800000 gives 0.
  - 0xC00000 gives -32767.
- Tick asserted during a sweep: the sweep is unchanged, no extra valid cycles appear, and overrun=1 stays set until rst_n=0.
- Drop rst_n mid-sweep at pipeline stage 2: out_valid=0 immediately, and all outputs and overrun are 0. The next tick restarts from channel 0 with phase 0.
- With OSC_HARDSYNC_EN defined, set freq[2]=0x100000, run 3 ticks, pulse sync_we with sync_ch=2, then tick: ch2 out_data=0.
